// File: rtl/puf_crp_ctrl_if.sv
// Request, response and PUF-side signal bundle for puf_crp_ctrl.
// master is the controller side; slave is the host/PUF environment side.
interface puf_crp_ctrl_if #(
  parameter int unsigned C_BITS = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [C_BITS-1:0] req_challenge;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [C_BITS-1:0] rsp_challenge;
  logic              rsp_bit;
  logic              rsp_stable;
  logic [C_BITS-1:0] puf_challenge;
  logic              puf_reset;
  logic              puf_enable;
  logic              puf_resp;
  logic              busy;

  modport master (
    input  req_valid, req_challenge, rsp_ready, puf_resp,
    output req_ready, rsp_valid, rsp_challenge, rsp_bit, rsp_stable,
           puf_challenge, puf_reset, puf_enable, busy
  );

  modport slave (
    output req_valid, req_challenge, rsp_ready, puf_resp,
    input  req_ready, rsp_valid, rsp_challenge, rsp_bit, rsp_stable,
           puf_challenge, puf_reset, puf_enable, busy
  );
endinterface

// File: rtl/puf_crp_ctrl.sv
// Arbiter PUF sequencer: challenge in, reset/gap/enable/settle, CRP out.
// Optional macro MAJORITY_VOTE_EN repeats the evaluation NUM_VOTES times and votes.
module puf_crp_ctrl #(
  parameter int unsigned C_BITS        = 8,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned NUM_VOTES     = 5
) (
  input  logic           i_clk,
  input  logic           i_reset,
  puf_crp_ctrl_if.master bus
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  if (RST_CYCLES < 1 || SETTLE_CYCLES < 1 || NUM_VOTES < 1 || (NUM_VOTES % 2) == 0) begin : g_bad_cfg
    $error("puf_crp_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {StIdle, StRst, StGap, StEval, StResp} state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [C_BITS-1:0] r_puf_challenge;
  logic [C_BITS-1:0] r_rsp_challenge;
  logic              r_puf_reset;
  logic              r_puf_enable;
  logic              r_rsp_valid;
  logic              r_rsp_bit;
  logic              r_rsp_stable;
  logic              r_busy;

`ifdef MAJORITY_VOTE_EN
  localparam int unsigned VOTE_W = (NUM_VOTES > 1) ? $clog2(NUM_VOTES) : 1;
  localparam int unsigned ONES_W = $clog2(NUM_VOTES + 1);

  logic [VOTE_W-1:0] r_vote;
  logic [ONES_W-1:0] r_ones;
  logic [ONES_W-1:0] w_ones_next;
  logic              w_last_vote;

  assign w_ones_next = r_ones + ONES_W'(bus.puf_resp);
  assign w_last_vote = (r_vote == VOTE_W'(NUM_VOTES - 1));
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= StIdle;
      r_cnt           <= '0;
      r_puf_challenge <= '0;
      r_rsp_challenge <= '0;
      r_puf_reset     <= 1'b0;
      r_puf_enable    <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_bit       <= 1'b0;
      r_rsp_stable    <= 1'b0;
      r_busy          <= 1'b0;
`ifdef MAJORITY_VOTE_EN
      r_vote          <= '0;
      r_ones          <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.req_valid) begin
            r_puf_challenge <= bus.req_challenge;
            r_rsp_challenge <= bus.req_challenge;
            r_puf_reset     <= 1'b1;
            r_busy          <= 1'b1;
            r_cnt           <= '0;
            r_state         <= StRst;
`ifdef MAJORITY_VOTE_EN
            r_vote          <= '0;
            r_ones          <= '0;
`endif
          end
        end
        StRst: begin
          if (r_cnt == RST_LAST) begin
            r_puf_reset <= 1'b0;
            r_cnt       <= '0;
            r_state     <= StGap;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StGap: begin
          r_puf_enable <= 1'b1;
          r_cnt        <= '0;
          r_state      <= StEval;
        end
        StEval: begin
          if (r_cnt == SETTLE_LAST) begin
            // The response is sampled on the edge that ends the last enable cycle
            r_puf_enable <= 1'b0;
            r_cnt        <= '0;
`ifdef MAJORITY_VOTE_EN
            r_ones <= w_ones_next;
            if (w_last_vote) begin
              r_rsp_bit    <= (w_ones_next > ONES_W'(NUM_VOTES / 2));
              r_rsp_stable <= (w_ones_next == '0) || (w_ones_next == ONES_W'(NUM_VOTES));
              r_rsp_valid  <= 1'b1;
              r_state      <= StResp;
            end else begin
              r_vote      <= r_vote + 1'b1;
              r_puf_reset <= 1'b1;
              r_state     <= StRst;
            end
`else
            r_rsp_bit    <= bus.puf_resp;
            r_rsp_stable <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_state      <= StResp;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready     = (r_state == StIdle) && !i_reset;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_challenge = r_rsp_challenge;
  assign bus.rsp_bit       = r_rsp_bit;
  assign bus.rsp_stable    = r_rsp_stable;
  assign bus.puf_challenge = r_puf_challenge;
  assign bus.puf_reset     = r_puf_reset;
  assign bus.puf_enable    = r_puf_enable;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_puf_crp_ctrl.sv
// Self-checking bench for puf_crp_ctrl with a behavioural PUF and a CRP scoreboard.
// Covers timing, parity sweep, backpressure, mid-run reset and (when enabled) majority voting.
module tb_puf_crp_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  puf_crp_ctrl_if #(.C_BITS(8)) u_if ();

  puf_crp_ctrl #(
    .C_BITS       (8),
    .RST_CYCLES   (2),
    .SETTLE_CYCLES(16),
    .NUM_VOTES    (5)
  ) u_dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  int n_pulse = 0;
  int p_base  = 0;
  int mode    = 1;  // 0: const 0, 1: const 1, 2: parity, 3: vote sequence
  logic [4:0] vote_seq = 5'b01101;
  logic       prev_rst = 1'b0;
  logic       w_model;
  logic [9:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always_comb begin
    w_model = 1'b0;
    case (mode)
      1: w_model = 1'b1;
      2: w_model = ^u_if.puf_challenge;
      3: begin
        if ((n_pulse - p_base) >= 1 && (n_pulse - p_base) <= 5)
          w_model = vote_seq[n_pulse - p_base - 1];
      end
      default: w_model = 1'b0;
    endcase
  end
  assign u_if.puf_resp = w_model;

  always @(posedge clk) begin
    prev_rst <= u_if.puf_reset;
    if (u_if.puf_reset && !prev_rst) n_pulse <= n_pulse + 1;
  end

  // Scoreboard pop on every response handshake
  always @(negedge clk) begin
    if (!reset && u_if.rsp_valid && u_if.rsp_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("rsp_spurious", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = sb_q.pop_front();
        check_eq("rsp_challenge", 32'(u_if.rsp_challenge), 32'(e[9:2]));
        check_eq("rsp_bit", 32'(u_if.rsp_bit), 32'(e[1]));
        check_eq("rsp_stable", 32'(u_if.rsp_stable), 32'(e[0]));
      end
      n_rsp++;
    end
  end

  task automatic send(input logic [7:0] c, input logic exp_bit, input logic exp_stable,
                      input bit push);
    int n = 0;
    while (!u_if.req_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) check_eq("req_ready_timeout", 32'd0, 32'd1);
    u_if.req_valid     = 1'b1;
    u_if.req_challenge = c;
    if (push) sb_q.push_back({c, exp_bit, exp_stable});
    @(posedge clk);
    #1;
    u_if.req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int base;
    int k;
    reset              = 1'b1;
    u_if.req_valid     = 1'b0;
    u_if.req_challenge = '0;
    u_if.rsp_ready     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(u_if.req_ready), 32'd0);
    check_eq("rst_busy", 32'(u_if.busy), 32'd0);
    check_eq("rst_puf_ctl", 32'({u_if.puf_reset, u_if.puf_enable}), 32'd0);
    check_eq("rst_rsp", 32'({u_if.rsp_valid, u_if.rsp_bit, u_if.rsp_stable}), 32'd0);
    check_eq("rst_chal", 32'({u_if.puf_challenge, u_if.rsp_challenge}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_ready", 32'(u_if.req_ready), 32'd1);

`ifndef MAJORITY_VOTE_EN
    // Cycle-exact single evaluation, T+k counted from the accept edge
    mode = 1;
    @(posedge clk);
    #1;
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    bad = 0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (u_if.puf_reset !== (i >= 1 && i <= 2)) bad++;
      if (u_if.puf_enable !== (i >= 4 && i <= 19)) bad++;
      if (u_if.rsp_valid !== (i == 20)) bad++;
      if (u_if.puf_challenge !== 8'hA5) bad++;
      if (i == 20) check_eq("t20_req_ready", 32'(u_if.req_ready), 32'd0);
      if (i == 21) check_eq("t21_req_ready", 32'(u_if.req_ready), 32'd1);
    end
    check_eq("single_eval_timing", 32'(bad), 32'd0);
`endif

    // Reset asserted during the edge that ends cycle T+10
    mode = 1;
    @(posedge clk);
    #1;
    send(8'h77, 1'b1, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    check_eq("mid_eval_enable", 32'(u_if.puf_enable), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_req_ready", 32'(u_if.req_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 32'(u_if.busy), 32'd0);
    check_eq("abort_puf_ctl", 32'({u_if.puf_reset, u_if.puf_enable}), 32'd0);
    check_eq("abort_chal", 32'(u_if.puf_challenge), 32'd0);
    check_eq("abort_req_ready", 32'(u_if.req_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.rsp_valid !== 1'b0) bad++;
    end
    check_eq("abort_no_rsp", 32'(bad), 32'd0);

    // Backpressure: result must hold for 50 cycles while new requests are ignored
    @(posedge clk);
    #1 u_if.rsp_ready = 1'b0;
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    k = 0;
    while (u_if.rsp_valid !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("bp_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      u_if.req_valid     = 1'b1;
      u_if.req_challenge = 8'(i + 1);
      @(negedge clk);
      if (u_if.rsp_valid !== 1'b1 || u_if.rsp_challenge !== 8'h3C) bad++;
      if (u_if.rsp_bit !== 1'b1 || u_if.req_ready !== 1'b0) bad++;
      if (u_if.puf_enable !== 1'b0 || u_if.puf_reset !== 1'b0) bad++;
      if (u_if.puf_challenge !== 8'h3C) bad++;
    end
    check_eq("bp_hold", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    u_if.req_valid = 1'b0;
    u_if.rsp_ready = 1'b1;
    drain("bp_drain");
    @(posedge clk);
    #1;
    check_eq("bp_release_valid", 32'(u_if.rsp_valid), 32'd0);
    check_eq("bp_release_ready", 32'(u_if.req_ready), 32'd1);

    // Full challenge sweep against a parity PUF
    mode = 2;
    base = n_rsp;
    for (int c = 0; c < 256; c++) begin
      logic [7:0] cv;
      cv = 8'(c);
      send(cv, ^cv, 1'b1, 1'b1);
    end
    drain("sweep_drain");
    check_eq("sweep_count", 32'(n_rsp - base), 32'd256);

`ifdef MAJORITY_VOTE_EN
    mode   = 3;
    p_base = n_pulse;
    send(8'h5A, 1'b1, 1'b0, 1'b1);
    k = 1;
    @(negedge clk);
    while (u_if.rsp_valid !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("vote_latency", 32'(k), 32'd96);
    drain("vote_seq_drain");
    mode   = 0;
    p_base = n_pulse;
    send(8'hC3, 1'b0, 1'b1, 1'b1);
    drain("vote_const_drain");
    check_eq("vote_reset_pulses", 32'(n_pulse - p_base), 32'd5);
`endif

    repeat (5) @(posedge clk);
    check_eq("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
